// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters.
// Accept on valid&ready in IDLE, tx_start one cycle later, then track tx_busy (with rise timeout) back to IDLE.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          active,
  output logic                          err_timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [IDW-1:0]    winner;
  logic [IDW-1:0]    idx;
  logic              found;
  logic              grant_ok;

  // Search starts at rr_ptr and wraps naturally in IDW bits.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = rr_ptr_q + IDW'(k);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // rst_n gating keeps req_ready low throughout reset regardless of inputs.
  assign grant_ok  = rst_n && (state_q == IDLE) && ena && !tx_busy && found;
  assign req_ready = grant_ok ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    tx_data_d   = tx_data_q;
    cnt_d       = cnt_q;
    tx_start    = 1'b0;
    err_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          tx_data_d  = req_data[int'(winner)*DATA_W +: DATA_W];
          grant_id_d = winner;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
          rr_ptr_d    = grant_id_q + IDW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d  = IDLE;
          rr_ptr_d = grant_id_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle model plus byte scoreboard, with directed scenarios on top.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_timeout;

  logic        auto_tx;
  logic        tx_busy_m;
  logic        tx_busy_d;
  int          busy_len;

  int checks = 0;
  int errors = 0;

  logic [9:0]  sb[$];
  int          grant_log[$];

  int          m_st, m_ptr, m_gid, m_wb;
  logic [7:0]  m_dat;

  assign tx_busy = auto_tx ? tx_busy_m : tx_busy_d;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Transmitter model: busy rises one cycle after tx_start and holds busy_len cycles.
  always begin
    @(negedge clk);
    if (auto_tx && tx_start) begin
      @(posedge clk); #1 tx_busy_m = 1'b1;
      repeat (busy_len) @(posedge clk);
      #1 tx_busy_m = 1'b0;
    end
  end

  // Cycle model: expected outputs for the current cycle, scoreboard of accepted bytes.
  always @(negedge clk) begin
    int w, nxt;
    logic [3:0] exp_rdy;
    logic exp_err;
    logic [9:0] e;
    if (!rst_n) begin
      m_st = 0; m_ptr = 0; m_gid = 0; m_wb = 0; m_dat = 8'h00;
      sb.delete();
    end else begin
      exp_rdy = 4'b0000;
      exp_err = 1'b0;
      nxt = m_st;
      case (m_st)
        0: begin
          w = rr_pick(req_valid, m_ptr);
          if (ena && !tx_busy && w >= 0) begin
            exp_rdy = 4'b0001 << w;
            sb.push_back({w[1:0], req_data[w*8 +: 8]});
            grant_log.push_back(w);
            m_gid = w;
            nxt = 1;
          end
        end
        1: begin
          if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            m_dat = e[7:0];
            chk("sb_grant_id", 32'(grant_id), 32'(e[9:8]));
          end
          m_wb = 0;
          nxt = 2;
        end
        2: begin
          if (tx_busy) nxt = 3;
          else begin
            m_wb++;
            if (m_wb == 3) begin
              exp_err = 1'b1;
              m_ptr = (m_gid + 1) % 4;
              nxt = 0;
            end
          end
        end
        default: begin
          if (!tx_busy) begin
            m_ptr = (m_gid + 1) % 4;
            nxt = 0;
          end
        end
      endcase
      if (m_st != 0) chk("tx_data", 32'(tx_data), 32'(m_dat));
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("tx_start", 32'(tx_start), 32'(m_st == 1));
      chk("err_timeout", 32'(err_timeout), 32'(exp_err));
      chk("active", 32'(active), 32'(m_st != 0));
      m_st = nxt;
    end
  end

  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin got = 1; break; end
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!active) begin got = 1; break; end
    end
    if (!got) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_busy();
    bit got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_busy) begin got = 1; break; end
    end
    if (!got) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g, n, cnt;
    rst_n = 1'b0; ena = 1'b1; req_valid = 4'b1111;
    req_data = 32'hD3_41_B2_5A;
    auto_tx = 1'b1; tx_busy_m = 1'b0; tx_busy_d = 1'b0; busy_len = 4;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Fairness with all requesters held valid from reset.
    base = grant_log.size();
    for (int i = 0; i < 6; i++) wait_accept();
    req_valid = 4'b0000;
    wait_idle();
    for (int i = 0; i < 6; i++) chk("fair_order", 32'(grant_log[base + i]), 32'(i % 4));

    // Single request from requester 2, then pointer moves to 3.
    busy_len = 10;
    req_valid = 4'b0100;
    wait_accept();
    req_valid = 4'b0000;
    chk("single_id", 32'(grant_log[$]), 32'd2);
    wait_idle();
    req_valid = 4'b1111;
    wait_accept();
    req_valid = 4'b0000;
    chk("ptr_after_single", 32'(grant_log[$]), 32'd3);
    wait_idle();

    // Timeout with tx_busy stuck low.
    auto_tx = 1'b0; tx_busy_d = 1'b0;
    req_valid = 4'b1111;
    wait_accept();
    g = grant_log[$];
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (err_timeout) break;
      n++;
    end
    chk("timeout_latency", 32'(n), 32'd3);
    @(posedge clk); #1;
    wait_accept();
    req_valid = 4'b0000;
    chk("timeout_next_id", 32'(grant_log[$]), 32'((g + 1) % 4));
    wait_idle();

    // Enable gating.
    auto_tx = 1'b1; busy_len = 8;
    ena = 1'b0; req_valid = 4'b1111;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) cnt++;
    end
    chk("ena_gate_ready", 32'(cnt), 32'd0);
    @(posedge clk); #1 ena = 1'b1;
    wait_accept();
    wait_busy();
    @(posedge clk); #1 ena = 1'b0;
    base = grant_log.size();
    wait_idle();
    repeat (10) @(posedge clk);
    #1 chk("ena_drop_no_grant", 32'(grant_log.size()), 32'(base));
    req_valid = 4'b0000; ena = 1'b1;

    // Reset during WAIT_DONE of a grant to requester 2.
    req_valid = 4'b0100;
    wait_accept();
    req_valid = 4'b0000;
    chk("rst_case_id", 32'(grant_log[$]), 32'd2);
    wait_busy();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_err", 32'(err_timeout), 32'd0);
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = grant_log.size();
    wait_accept();
    req_valid = 4'b0000;
    chk("post_rst_first", 32'(grant_log[base]), 32'd0);
    wait_idle();

    // tx_busy held externally in IDLE.
    auto_tx = 1'b0; tx_busy_d = 1'b1;
    req_valid = 4'b0001;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) cnt++;
    end
    chk("busy_hold_ready", 32'(cnt), 32'd0);
    @(posedge clk); #1 tx_busy_d = 1'b0;
    @(negedge clk);
    chk("busy_fall_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = 4'b0000;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
